// File: rtl/prog_frame_sender.sv
// prog_frame_sender: shifts one configuration frame MSB-first over SCLK/CS/SDI with CS setup, hold and gap framing.
module prog_frame_sender #(
  parameter int FRAME_BITS = 64,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 8,
  parameter int CS_HOLD    = 8,
  parameter int CS_GAP     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame_data,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  SDI
);
  localparam int M1 = CLK_DIV > CS_SETUP ? CLK_DIV : CS_SETUP;
  localparam int M2 = CS_HOLD > CS_GAP ? CS_HOLD : CS_GAP;
  localparam int PW = $clog2(M1 > M2 ? M1 : M2) + 1;
  localparam int BW = $clog2(FRAME_BITS) + 1;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, n_state;
  logic [FRAME_BITS-1:0] sr, n_sr;
  logic [PW-1:0] pc, n_pc, lim;
  logic [BW-1:0] bc, n_bc;
  logic n_busy, n_done, n_sclk, n_cs, n_sdi, expire;
  always_comb begin
    lim = state == SETUP ? PW'(CS_SETUP - 1) : state == HOLD ? PW'(CS_HOLD - 1) :
          state == GAP ? PW'(CS_GAP - 1) : PW'(CLK_DIV - 1);
    expire = pc == lim;
  end
  always_comb begin
    n_state = state;
    n_sr = sr;
    n_pc = expire ? '0 : pc + 1'b1;
    n_bc = bc;
    n_busy = busy;
    n_done = 1'b0;
    n_sclk = SCLK;
    n_cs = CS;
    n_sdi = SDI;
    case (state)
      IDLE: begin
        n_pc = '0;
        if (start) begin
          n_state = SETUP;
          n_sr = frame_data;
          n_sdi = frame_data[FRAME_BITS-1];
          n_bc = '0;
          n_cs = 1'b0;
          n_busy = 1'b1;
        end
      end
      SETUP: if (expire) begin
        n_state = SHIFT;
        n_sclk = 1'b1;
      end
      SHIFT: begin
        // the final low half-period is replaced by HOLD
        if (expire && SCLK && bc == BW'(FRAME_BITS - 1)) begin
          n_state = HOLD;
          n_sclk = 1'b0;
          n_sdi = 1'b0;
        end else if (expire && SCLK) begin
          n_sclk = 1'b0;
          n_sr = sr << 1;
          n_sdi = sr[FRAME_BITS-2];
        end else if (expire) begin
          n_sclk = 1'b1;
          n_bc = bc + 1'b1;
        end
      end
      HOLD: if (expire) begin
        n_state = GAP;
        n_cs = 1'b1;
        n_done = 1'b1;
      end
      GAP: if (expire) begin
        n_state = IDLE;
        n_busy = 1'b0;
      end
      default: n_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      pc <= '0;
      bc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      SCLK <= 1'b0;
      CS <= 1'b1;
      SDI <= 1'b0;
    end else begin
      state <= n_state;
      sr <= n_sr;
      pc <= n_pc;
      bc <= n_bc;
      busy <= n_busy;
      done <= n_done;
      SCLK <= n_sclk;
      CS <= n_cs;
      SDI <= n_sdi;
    end
  end
endmodule

// File: tb/tb_prog_frame_sender.sv
// tb_prog_frame_sender: directed checks of framing, timing, rejection, back-to-back and abort behaviour.
module tb_prog_frame_sender;
  logic clk = 1'b0;
  logic reset = 1'b1, start_a = 1'b0, start_b = 1'b0;
  logic [63:0] data_a = '0, data_b = '0;
  logic busy_a, done_a, sclk_a, cs_a, sdi_a;
  logic busy_b, done_b, sclk_b, cs_b, sdi_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  prog_frame_sender dut_a (
    .clk(clk), .reset(reset), .start(start_a), .frame_data(data_a),
    .busy(busy_a), .done(done_a), .SCLK(sclk_a), .CS(cs_a), .SDI(sdi_a)
  );
  prog_frame_sender #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(3), .CS_GAP(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .frame_data(data_b),
    .busy(busy_b), .done(done_b), .SCLK(sclk_b), .CS(cs_b), .SDI(sdi_b)
  );

  // observers for the default instance
  int rises_a = 0, done_cnt_a = 0, done_bad = 0, brun_a = 0, blen_a = 0;
  int chrun = 0, cs_high = 0, seg = 0, seg_last = 0, seg_prev = 0, viol_a = 0;
  logic [63:0] cap_a = '0;
  logic psclk_a = 1'b0, pcs_a = 1'b1, pbusy_a = 1'b0;
  always @(negedge clk) begin
    if (sclk_a && !psclk_a && !cs_a) begin
      rises_a++;
      seg++;
      cap_a = {cap_a[62:0], sdi_a};
    end
    if (done_a === 1'b1) begin
      done_cnt_a++;
      if (!(cs_a && !pcs_a)) done_bad++;
    end
    if (busy_a === 1'b1) brun_a++;
    else if (pbusy_a) begin
      blen_a = brun_a;
      brun_a = 0;
    end
    if (cs_a === 1'b1) chrun++;
    else if (pcs_a) begin
      cs_high = chrun;
      chrun = 0;
      seg = 0;
    end
    if (cs_a === 1'b1 && !pcs_a) begin
      seg_prev = seg_last;
      seg_last = seg;
    end
    if (sclk_a === 1'b1 && cs_a === 1'b1) viol_a++;
    psclk_a = sclk_a === 1'b1;
    pcs_a = cs_a !== 1'b0;
    pbusy_a = busy_a === 1'b1;
  end

  // observers for the fast instance
  int cyc = 0, rises_b = 0, t_fall = 0, t_rise0 = 0, t_last = 0, t_sfall = 0;
  int hold_b = 0, bad_per = 0, viol_b = 0, brun_b = 0, blen_b = 0;
  logic first_b = 1'b0;
  logic [63:0] cap_b = '0;
  logic psclk_b = 1'b0, pcs_b = 1'b1, psdi_b = 1'b0, pbusy_b = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (cs_b === 1'b0 && pcs_b) begin
      t_fall = cyc;
      first_b = 1'b1;
    end
    if (sclk_b && !psclk_b && !cs_b) begin
      rises_b++;
      cap_b = {cap_b[62:0], sdi_b};
      if (first_b) t_rise0 = cyc;
      else if (cyc - t_last != 2) bad_per++;
      first_b = 1'b0;
      t_last = cyc;
    end
    if (sclk_b === 1'b0 && psclk_b) t_sfall = cyc;
    if (cs_b === 1'b1 && !pcs_b) hold_b = cyc - t_sfall;
    if (sclk_b === 1'b1 && (sdi_b !== psdi_b || cs_b !== 1'b0)) viol_b++;
    if (busy_b === 1'b1) brun_b++;
    else if (pbusy_b) begin
      blen_b = brun_b;
      brun_b = 0;
    end
    psclk_b = sclk_b === 1'b1;
    pcs_b = cs_b !== 1'b0;
    psdi_b = sdi_b;
    pbusy_b = busy_b === 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bound(input string tag, input int t);
    checks++;
    assert (t < 5000) else begin
      errors++;
      $error("FAIL %s observed=timeout expected=event", tag);
    end
  endtask

  task automatic wait_rises(input int target);
    int t = 0;
    while (rises_a < target && t < 5000) begin
      tick();
      t++;
    end
    bound("wait_rises", t);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy_a !== 1'b0 || busy_b !== 1'b0) && t < 5000) begin
      tick();
      t++;
    end
    bound("wait_idle", t);
  endtask

  task automatic pulse_a(input logic [63:0] d);
    data_a = d;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  logic [7:0] sw_bytes [8] = '{8'h05, 8'hBD, 8'hD9, 8'hDA, 8'hB3, 8'h21, 8'hA1, 8'hA5};
  int r0, d0;
  logic [63:0] cap_first;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check("reset_a", {cs_a, sclk_a, sdi_a, busy_a, done_a}, 64'h10);
    check("reset_b", {cs_b, sclk_b, sdi_b, busy_b, done_b}, 64'h10);
    // single frame on both instances
    r0 = rises_a;
    d0 = done_cnt_a;
    data_b = 64'hC3A5_0F96_1E2D_4B78;
    start_b = 1'b1;
    pulse_a(64'h05BD_D9DA_B321_A1A5);
    start_b = 1'b0;
    check("busy_rise", busy_a, 1'b1);
    check("cs_fall", cs_a, 1'b0);
    wait_idle();
    tick();
    check("single_rises", rises_a - r0, 64);
    check("single_data", cap_a, 64'h05BD_D9DA_B321_A1A5);
    check("single_busy_len", blen_a, 532);
    check("single_done", done_cnt_a - d0, 1);
    for (int i = 0; i < 8; i++) check("prog_byte", cap_a[63-8*i -: 8], sw_bytes[i]);
    check("fast_rises", rises_b, 64);
    check("fast_data", cap_b, 64'hC3A5_0F96_1E2D_4B78);
    check("fast_first_rise", t_rise0 - t_fall, 2);
    check("fast_period", bad_per, 0);
    check("fast_sdi_stable", viol_b, 0);
    check("fast_cs_hold", hold_b, 3);
    check("fast_busy_len", blen_b, 140);
    // start during a busy frame is dropped
    r0 = rises_a;
    d0 = done_cnt_a;
    pulse_a(64'h0);
    wait_rises(r0 + 10);
    pulse_a(64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();
    repeat (30) tick();
    check("reject_busy", busy_a, 1'b0);
    check("reject_rises", rises_a - r0, 64);
    check("reject_data", cap_a, 64'h0);
    check("reject_done", done_cnt_a - d0, 1);
    // back-to-back with start held
    r0 = rises_a;
    d0 = done_cnt_a;
    data_a = 64'hAAAA_5555_0F0F_F0F0;
    start_a = 1'b1;
    wait_rises(r0 + 64);
    cap_first = cap_a;
    data_a = 64'h1234_5678_9ABC_DEF0;
    wait_rises(r0 + 65);
    start_a = 1'b0;
    check("b2b_cs_high", cs_high, 9);
    wait_rises(r0 + 128);
    check("b2b_a", cap_first, 64'hAAAA_5555_0F0F_F0F0);
    check("b2b_b", cap_a, 64'h1234_5678_9ABC_DEF0);
    wait_idle();
    repeat (12) tick();
    check("b2b_rises", rises_a - r0, 128);
    check("b2b_done", done_cnt_a - d0, 2);
    // reset mid-SHIFT aborts the frame
    r0 = rises_a;
    d0 = done_cnt_a;
    pulse_a(64'hFFFF_0000_FFFF_0000);
    wait_rises(r0 + 20);
    reset = 1'b1;
    start_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_reset", {cs_a, sclk_a, sdi_a, busy_a, done_a}, 64'h10);
    end
    reset = 1'b0;
    start_a = 1'b0;
    repeat (4) tick();
    check("abort_idle", {busy_a, cs_a}, 64'h1);
    pulse_a(64'h8000_0000_0000_0001);
    wait_idle();
    tick();
    check("abort_seg_partial", seg_prev, 20);
    check("abort_seg_full", seg_last, 64);
    check("abort_data", cap_a, 64'h8000_0000_0000_0001);
    check("abort_done", done_cnt_a - d0, 1);
    check("done_with_cs_rise", done_bad, 0);
    check("sclk_while_cs_high", viol_a, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
